// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for ram_stream_reader and the RAM instantiation it reads.
package ram_stream_reader_pkg;

  localparam int unsigned DEF_MEM_WIDTH = 8;
  localparam int unsigned DEF_MEM_SIZE  = 896;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Address increment with wrap at an arbitrary (non power-of-2) depth
  function automatic int unsigned addr_wrap(input int unsigned addr, input int unsigned size);
    return (addr >= size - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/ram_stream_reader_skid_fifo2.sv
// skid_fifo2: generic 2-entry FIFO; head entry and valid come straight from flops.
module skid_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] e0_q, e1_q;
  logic [1:0]       count_q, count_d;
  logic             valid_q;
  logic             pop_ok, push_ok;

  // Qualify push/pop against occupancy and compute next count
  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'd2) || pop_ok);
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 2'd1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 2'd1;
    end
  end

  // Storage: e0 is always the head, e1 the entry behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != 2'd0);
      if (pop_ok) begin
        if (push_ok && (count_q == 2'd1)) begin
          e0_q <= din;
        end else begin
          e0_q <= e1_q;
        end
        if (push_ok && (count_q == 2'd2)) begin
          e1_q <= din;
        end
      end else if (push_ok) begin
        if (count_q == 2'd0) begin
          e0_q <= din;
        end else begin
          e1_q <= din;
        end
      end
    end
  end

  assign head       = e0_q;
  assign head_valid = valid_q;
  assign count      = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads len words from a registered-output block RAM starting
// at base_addr (wrapping at MEM_SIZE) and emits them as a valid/ready stream.
// Optional macro STREAM_LAST_EN adds a dout_last output marking the final word.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int unsigned MEM_SIZE  = DEF_MEM_SIZE,
  localparam int unsigned ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      len,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_en,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 dout_valid,
`ifdef STREAM_LAST_EN
  output logic                 dout_last,
`endif
  input  logic                 dout_ready
);

  localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef STREAM_LAST_EN
  localparam int unsigned FIFO_W = MEM_WIDTH + 1;
`else
  localparam int unsigned FIFO_W = MEM_WIDTH;
`endif

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   len_q, issued_q;
  logic               inflight_q, busy_q, done_q;
  logic               pop, last_issue;
  logic [1:0]         fifo_count, occ;
  logic [FIFO_W-1:0]  fifo_din, fifo_head;
  logic               fifo_valid;

  assign pop        = fifo_valid && dout_ready;
  assign occ        = fifo_count + 2'(inflight_q);
  assign last_issue = ((issued_q + CNT_W'(1)) == len_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: drain ends when the final word leaves the FIFO with nothing in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (len != '0) ? ST_READ : ST_FINISH;
        end
      end
      ST_READ: begin
        if (ram_en && last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q &&
            ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read issue: a slot freed by this cycle's pop may be reused immediately
  always_comb begin
    ram_en = 1'b0;
    if ((state_q == ST_READ) && (issued_q < len_q) &&
        ((occ < 2'd2) || pop)) begin
      ram_en = 1'b1;
    end
  end

  // Transfer bookkeeping, address generation and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= ram_en;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_FINISH);
      if ((state_q == ST_IDLE) && start) begin
        addr_q   <= base_addr;
        len_q    <= len;
        issued_q <= '0;
      end else if (ram_en) begin
        addr_q   <= ADDR_W'(addr_wrap(32'(addr_q), MEM_SIZE));
        issued_q <= issued_q + CNT_W'(1);
      end
    end
  end

`ifdef STREAM_LAST_EN
  logic inflight_last_q;

  // Tag the word currently in flight as the final one of the transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_last_q <= 1'b0;
    end else begin
      inflight_last_q <= ram_en && last_issue;
    end
  end

  assign fifo_din  = {inflight_last_q, ram_dout};
  assign dout      = fifo_head[MEM_WIDTH-1:0];
  assign dout_last = fifo_head[MEM_WIDTH] && fifo_valid;
`else
  assign fifo_din  = ram_dout;
  assign dout      = fifo_head;
`endif

  skid_fifo2 #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q),
    .din        (fifo_din),
    .pop        (pop),
    .head       (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign dout_valid = fifo_valid;
  assign ram_addr   = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: vector table + random transfers
// checked against a word-list model of the RAM contents.
module tb_ram_stream_reader;
  import ram_stream_reader_pkg::*;

  localparam int unsigned MW = DEF_MEM_WIDTH;
  localparam int unsigned MS = DEF_MEM_SIZE;
  localparam int unsigned AW = $clog2(MS);

  typedef struct {
    int base;
    int n;
    int mode;      // ready pattern
    int extra;     // cycle of an ignored second start, -1 none
    int exp_done;  // expected done cycle, -1 = not timed
    int exp_fv;    // expected first dout_valid cycle (-1 = never)
  } vec_t;

  logic           clk, rst_n, start, dout_ready;
  logic [AW-1:0]  base_addr, ram_addr;
  logic [AW:0]    len;
  logic           busy, done, ram_en, dout_valid, mon_last;
  logic [MW-1:0]  ram_dout = '0;
  logic [MW-1:0]  dout;
`ifdef STREAM_LAST_EN
  logic           dout_last;
  assign mon_last = dout_last;
`else
  assign mon_last = 1'b0;
`endif

  logic [MW-1:0] mem [MS];
  int cyc = 0;
  int t0_g = 0;
  int rdy_mode = 0;
  int n_cmp = 0;
  int n_err = 0;

  int rx_words[$];
  int rx_addr[$];
  int rx_last[$];
  int issued, xfers, done_cnt, done_cyc, first_valid, occ_viol, stab_viol, last_viol;
  logic          prev_stall;
  logic [MW:0]   prev_beat;
  vec_t          tbl[$];

  ram_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .dout       (dout),
    .dout_valid (dout_valid),
`ifdef STREAM_LAST_EN
    .dout_last  (dout_last),
`endif
    .dout_ready (dout_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Block RAM: registered read, enable gated
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  function automatic logic rdy_of(input int mode, input int k);
    case (mode)
      1:       return ((k % 2) == 0) && !((k >= 8) && (k <= 14));
      2:       return ($urandom_range(0, 3) != 0);
      3:       return !((k >= 6) && (k <= 10));
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      dout_ready = rdy_of(rdy_mode, cyc - t0_g);
    end
  end

  // Stream / RAM-port monitor sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_en) begin
        rx_addr.push_back(int'(ram_addr));
        issued++;
      end
      if (dout_valid && dout_ready) begin
        rx_words.push_back(int'(dout));
        rx_last.push_back(int'(mon_last));
        xfers++;
      end
      if (dout_valid && (first_valid < 0)) first_valid = cyc - t0_g;
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0_g;
      end
      if ((issued - xfers) > 2) occ_viol++;
      if (mon_last && !dout_valid) last_viol++;
      if (prev_stall && (!dout_valid || ({mon_last, dout} != prev_beat))) stab_viol++;
      prev_stall = dout_valid && !dout_ready;
      prev_beat  = {mon_last, dout};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    rx_words.delete();
    rx_addr.delete();
    rx_last.delete();
    issued = 0; xfers = 0; done_cnt = 0; done_cyc = -1; first_valid = -1;
    occ_viol = 0; stab_viol = 0; last_viol = 0;
  endtask

  function automatic void add(input int b, input int n, input int m, input int x,
                              input int ed, input int fv);
    vec_t v;
    v.base = b; v.n = n; v.mode = m; v.extra = x; v.exp_done = ed; v.exp_fv = fv;
    tbl.push_back(v);
  endfunction

  task automatic run_xfer(input vec_t v);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    rdy_mode  = v.mode;
    t0_g      = cyc;
    base_addr = AW'(v.base);
    len       = (AW+1)'(v.n);
    start     = 1'b1;
    for (int k = 1; k <= 4 * v.n + 60; k++) begin
      @(posedge clk); #1;
      start = (k == v.extra);
      if (k == v.extra) begin
        base_addr = AW'($urandom_range(0, MS - 1));
        len       = (AW+1)'($urandom_range(1, MS));
      end
      if (done_cnt > 0) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("busy_after", busy, 0);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("word_count", rx_words.size(), v.n);
    chk("addr_count", rx_addr.size(), v.n);
    for (int i = 0; i < v.n; i++) begin
      int a;
      a = (v.base + i) % MS;
      if (i < rx_addr.size()) chk("addr", rx_addr[i], a);
      if (i < rx_words.size()) begin
        chk("word", rx_words[i], mem[a]);
`ifdef STREAM_LAST_EN
        chk("last", rx_last[i], int'(i == v.n - 1));
`endif
      end
    end
    chk("occupancy", occ_viol, 0);
    chk("stability", stab_viol, 0);
    chk("last_align", last_viol, 0);
    if (v.exp_done >= 0) begin
      chk("done_cycle", done_cyc, v.exp_done);
      chk("first_valid", first_valid, v.exp_fv);
    end
  endtask

  task automatic rst_mid();
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    rdy_mode  = 0;
    t0_g      = cyc;
    base_addr = AW'(37);
    len       = (AW+1)'(20);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (xfers >= 5) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rst_reach5", got, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_idle_busy", busy, 0);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    for (int i = 0; i < MS; i++) mem[i] = MW'(i);
    clear_mon();
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ram_en", ram_en, 0);
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_dout", dout, 0);
    chk("reset_dout_valid", dout_valid, 0);
`ifdef STREAM_LAST_EN
    chk("reset_dout_last", dout_last, 0);
`endif
    #1 rst_n = 1'b1;

    add(0,   896, 0, -1, 899, 3);   // full buffer, ascending pattern
    add(890, 10,  0, -1, 13,  3);   // address wrap
    add(0,   16,  1, -1, -1,  0);   // toggling ready + 7-cycle stall
    add(5,   0,   0, -1, 1,  -1);   // zero length
    add(100, 20,  0, 5,  23,  3);   // ignored start while busy
    add(895, 1,   0, -1, 4,   3);   // single word at last address
    add(3,   2,   2, -1, -1,  0);
    add(700, 40,  2, -1, -1,  0);
`ifdef STREAM_LAST_EN
    add(10,  4,   3, -1, 12,  3);   // stall on final word
`endif
    for (int r = 0; r < 6; r++) begin
      int n, m;
      n = $urandom_range(1, 48);
      m = $urandom_range(0, 2);
      add($urandom_range(0, MS - 1), n, m, -1, (m == 0) ? n + 3 : -1, 3);
    end

    foreach (tbl[i]) begin
      run_xfer(tbl[i]);
      if (i == 0) foreach (mem[j]) mem[j] = MW'($urandom);
    end

    rst_mid();
    add(200, 12, 0, -1, 15, 3);
    v = tbl[tbl.size() - 1];
    run_xfer(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
